// File: rtl/count_mon_pkg.sv
// Shared types for count_event_monitor: event kinds, FSM states, event record,
// plus a saturating adder used by the optional statistics counters.
package count_mon_pkg;

    localparam int MON_CW = 4;
    localparam int MON_EW = 8;

    typedef enum logic {
        EVT_MATCH = 1'b0,
        EVT_WRAP  = 1'b1
    } evt_kind_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PEND  = 2'd2
    } mon_state_t;

    typedef struct packed {
        evt_kind_t          kind;
        logic [MON_CW-1:0]  count;
        logic [MON_EW-1:0]  epoch;
    } evt_rec_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'b0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/evt_fifo2.sv
// Two-entry FIFO for event records. Accepts up to two pushes per cycle; the
// caller only pushes into free slots, counting a slot freed by a same-cycle pop.
module evt_fifo2 #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push0,
    input  logic [W-1:0] din0,
    input  logic         push1,
    input  logic [W-1:0] din1,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [1:0] level_reg;
    logic       rd_ptr_reg;
    logic       do_pop;
    logic       wr_ptr0;
    logic       wr_ptr1;

    assign do_pop  = pop && (level_reg != 2'd0);
    // With two entries the write slot is the read slot offset by the fill level.
    assign wr_ptr0 = rd_ptr_reg ^ level_reg[0];
    assign wr_ptr1 = wr_ptr0 ^ push0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [W-1:0] slot_reg;
            logic         we0;
            logic         we1;

            assign we0 = push0 && (wr_ptr0 == 1'(gi));
            assign we1 = push1 && (wr_ptr1 == 1'(gi));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    slot_reg <= '0;
                end else if (we0) begin
                    slot_reg <= din0;
                end else if (we1) begin
                    slot_reg <= din1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            level_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
        end else begin
            level_reg <= level_reg + 2'(push0) + 2'(push1) - 2'(do_pop);
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    assign dout  = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
    assign full  = (level_reg == 2'd2);
    assign empty = (level_reg == 2'd0);

endmodule

// File: rtl/count_event_monitor.sv
// Watches an upstream counter: tracks wraps in an epoch register, emits MATCH/WRAP
// records over valid/ready and flags bad steps. COUNT_MON_STATS_EN adds drop/match counters.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int CW = 4,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] count_in,
    input  logic          count_vld,
    input  logic          arm,
    input  logic          oneshot,
    input  logic [CW-1:0] cmp,
    output logic          evt_valid,
    input  logic          evt_ready,
    output logic          evt_kind,
    output logic [CW-1:0] evt_count,
    output logic [EW-1:0] evt_epoch,
    output logic          armed,
    output logic          seq_err
`ifdef COUNT_MON_STATS_EN
    ,
    output logic [7:0]    drop_cnt,
    output logic [7:0]    match_cnt
`endif
);

    localparam int RW = 1 + CW + EW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] prev_reg;
    logic          prev_vld_reg;
    logic [EW-1:0] epoch_reg;
    logic [EW-1:0] epoch_next;
    logic [CW-1:0] cmp_reg;
    logic [CW-1:0] prev_inc;
    mon_state_t    state_reg;
    logic          armed_reg;
    logic          seq_err_reg;

    logic          sample_chk;
    logic          is_wrap;
    logic          step_bad;
    logic          is_match;
    logic          pop_fire;
    logic          match_ack;
    logic [1:0]    free_slots;
    logic          match_push;
    logic          wrap_push;

    logic          fifo_push0;
    logic          fifo_push1;
    logic [RW-1:0] fifo_din0;
    logic [RW-1:0] match_rec;
    logic [RW-1:0] wrap_rec;
    logic [RW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;

    assign prev_inc   = prev_reg + CW'(1);
    assign sample_chk = count_vld && prev_vld_reg;
    assign is_wrap    = sample_chk && (prev_reg == CNT_MAX) && (count_in == '0);
    // A drop to zero from anywhere but the top is an upstream reset, not an error.
    assign step_bad   = sample_chk && (count_in != prev_inc) && (count_in != '0);
    assign epoch_next = epoch_reg + {{(EW-1){1'b0}}, is_wrap};
    assign is_match   = count_vld && (state_reg == S_ARMED) && (count_in == cmp_reg);

    assign pop_fire   = evt_valid && evt_ready;
    assign match_ack  = pop_fire && (fifo_dout[RW-1] == EVT_MATCH);
    assign free_slots = fifo_full  ? {1'b0, pop_fire} :
                        fifo_empty ? 2'd2 :
                        (pop_fire ? 2'd2 : 2'd1);

    // MATCH takes the first free slot; WRAP needs the slot after it.
    assign match_push = is_match && (free_slots != 2'd0);
    assign wrap_push  = is_wrap && (free_slots > {1'b0, match_push});

    assign match_rec  = {EVT_MATCH, count_in, epoch_next};
    assign wrap_rec   = {EVT_WRAP, count_in, epoch_next};
    assign fifo_push0 = match_push || wrap_push;
    assign fifo_push1 = match_push && wrap_push;
    assign fifo_din0  = match_push ? match_rec : wrap_rec;

    evt_fifo2 #(
        .W(RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push0 (fifo_push0),
        .din0  (fifo_din0),
        .push1 (fifo_push1),
        .din1  (wrap_rec),
        .pop   (evt_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_reg     <= '0;
            prev_vld_reg <= 1'b0;
            epoch_reg    <= '0;
            seq_err_reg  <= 1'b0;
        end else begin
            if (count_vld) begin
                prev_reg     <= count_in;
                prev_vld_reg <= 1'b1;
            end
            epoch_reg <= epoch_next;
            if (step_bad) begin
                seq_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            armed_reg <= 1'b0;
            cmp_reg   <= '0;
        end else begin
            if (arm) begin
                cmp_reg <= cmp;
            end
            case (state_reg)
                S_IDLE: begin
                    if (arm) begin
                        state_reg <= S_ARMED;
                        armed_reg <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (match_push) begin
                        state_reg <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (match_ack) begin
                        state_reg <= oneshot ? S_IDLE : S_ARMED;
                        armed_reg <= ~oneshot;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    armed_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef COUNT_MON_STATS_EN
    logic [7:0] drop_cnt_reg;
    logic [7:0] match_cnt_reg;
    logic [1:0] n_drop;

    assign n_drop = 2'(is_match && !match_push) + 2'(is_wrap && !wrap_push);

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_reg  <= 8'd0;
            match_cnt_reg <= 8'd0;
        end else begin
            drop_cnt_reg <= sat_add8(drop_cnt_reg, n_drop);
            if (match_ack) begin
                match_cnt_reg <= match_cnt_reg + 8'd1;
            end
        end
    end

    assign drop_cnt  = drop_cnt_reg;
    assign match_cnt = match_cnt_reg;
`endif

    assign evt_valid = ~fifo_empty;
    assign {evt_kind, evt_count, evt_epoch} = fifo_dout;
    assign armed     = armed_reg;
    assign seq_err   = seq_err_reg;

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 4-bit up-counter. Samples the counter value each cycle and tracks wrap-arounds (15->0) in a wider epoch register.
- Emits timestamped events over a valid/ready handshake: compare MATCH and WRAP.
- Flags sequence errors, i.e. any sample that is not a +1 step.
- Sits between the counter and the event logger / display stage.

Parameters:
CW, 4, counter width; must match the upstream counter.
EW, 8, epoch (wrap count) width.

Ports:
clk  input  1  rising-edge clock, shared with upstream counter
rst  input  1  synchronous reset, active-low
count_in  input  CW  upstream counter value
count_vld  input  1  count_in sample valid this cycle
arm  input  1  pulse: arm compare (IDLE->ARMED)
oneshot  input  1  1: disarm after first MATCH; 0: re-arm automatically
cmp  input  CW  compare value, sampled on arm
evt_valid  output  1  event record valid
evt_ready  input  1  consumer accepts record
evt_kind  output  1  0=MATCH, 1=WRAP
evt_count  output  CW  count_in value at the event
evt_epoch  output  EW  epoch value at the event (after the wrap increment for WRAP)
armed  output  1  FSM in ARMED or PEND
seq_err  output  1  sticky sequence-error flag

Behaviour:
- Reset when rst==0 at a posedge clk. All outputs go to 0, epoch=0, FSM=IDLE, prev_vld=0, output buffer empty. Reset mid-handshake drops any pending record.
- Only cycles with count_vld=1 are samples. prev/prev_vld update on every sample.
- Sequence check, on a sample with prev_vld=1:
  - expected = prev+1 mod 2^CW.
  - count_in==0 with prev!=2^CW-1 is treated as an upstream reset: no error, epoch unchanged.
  - Any other mismatch sets seq_err, which stays set until rst.
- WRAP: prev==2^CW-1 and count_in==0.
  - epoch <= epoch+1, wrapping at 2^EW with no saturation.
  - Enqueue a WRAP record.
- FSM states:
  - IDLE: arm -> ARMED, cmp latched.
  - ARMED: sample with count_in==cmp_q -> enqueue MATCH, then go to PEND.
  - PEND: waits for the MATCH record to be accepted, then -> IDLE if oneshot, else -> ARMED.
  - arm while ARMED/PEND re-latches cmp with no state change.
- Output buffer:
  - 2-entry FIFO.
  - Latency: a record appears on evt_* the cycle after the qualifying sample.
  - Transfer occurs when evt_valid && evt_ready. Outputs hold stable while evt_valid && !evt_ready.
- Simultaneous MATCH and WRAP on one sample: MATCH is enqueued first, WRAP second. Both require 2 free slots.
- FIFO full:
  - New events are dropped.
  - A dropped MATCH leaves the FSM in ARMED, so it can retry.
  - Enqueue and dequeue in the same cycle while full is allowed; the freed slot is usable.
- Upstream tb rate (1 sample per cycle) never overflows when evt_ready is tied high.

Optional Feature:
- Macro: COUNT_MON_STATS_EN.
- Defined:
  - Extra output drop_cnt [7:0], a saturating count of dropped events.
  - Extra output match_cnt [7:0], counts accepted MATCH records and wraps at 256.
  - Both reset to 0.
- Undefined: neither port exists and there is no counting logic. Core behaviour is identical either way.

Decomposition:
- Package count_mon_pkg:
  - evt_kind_t (EVT_MATCH=0, EVT_WRAP=1)
  - FSM state enum (S_IDLE, S_ARMED, S_PEND)
  - record struct {kind, count, epoch}
- Sub-module: evt_fifo2, a 2-entry valid/ready FIFO carrying the record, with push/full/pop/empty.

Test Plan:
- Reset, then 15 sequential samples 0..14, then 15, 0 -> one WRAP record with evt_count=0, evt_epoch=1. seq_err=0.
- arm with cmp=5, oneshot=1, counting 0..15 twice -> exactly one MATCH (count=5, epoch=0). armed=0 afterwards.
- oneshot=0, cmp=0, count through 15->0 -> MATCH then WRAP on the same sample, in that order, both with count=0, epoch=1.
- evt_ready=0 during 3 events -> 2 records held stable and the 3rd dropped (drop_cnt=1 with COUNT_MON_STATS_EN). Releasing ready drains 2 records in order.
- Sample sequence 3,4,7 -> seq_err=1, sticky. Sequence 3,4,0 -> no error, epoch unchanged.
- rst=0 while a record is pending -> evt_valid=0, epoch=0, FSM IDLE on the next edge.
